// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: state encodings, register-0
// constant, opcodes used by control, and the write-back enable rule.
package mips_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // A store never writes back, and r0 is hard-wired to zero.
  function automatic logic wb_enable(input logic       valid,
                                     input logic       reg_write,
                                     input logic       is_store,
                                     input logic [4:0] dest);
    return valid & reg_write & ~is_store & (dest != REG_ZERO);
  endfunction

endpackage

// File: rtl/mem_wb_pipe_stage_mux2.sv
// Generic 2:1 multiplexer shared across the core's datapath.
module mux2 #(
  parameter int mux_width = 32
) (
  input  logic [mux_width-1:0] a,
  input  logic [mux_width-1:0] b,
  input  logic                 sel,
  output logic [mux_width-1:0] y
);

  // Select b when sel is high, otherwise a.
  always_comb begin
    if (sel) begin
      y = b;
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM stage and MEM/WB pipeline register: drives a req/ack data memory,
// stalls upstream while an access is outstanding, and produces the WB triple.
module mem_wb_pipe_stage
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_mem_valid,
  input  logic [31:0]           ex_mem_alu_result,
  input  logic [31:0]           ex_mem_store_data,
  input  logic [4:0]            ex_mem_dest_reg,
  input  logic                  ex_mem_mem_to_reg,
  input  logic                  ex_mem_mem_read,
  input  logic                  ex_mem_mem_write,
  input  logic                  ex_mem_reg_write,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  mem_stall,
  output logic                  mem_error,
  output logic                  mem_wb_reg_write,
  output logic [4:0]            mem_wb_write_reg_addr,
  output logic [31:0]           mem_wb_write_back_data
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              access_s;
  logic              ack_s;
  logic              stall_s;
  logic              wb_load_s;
  logic              wb_sel_s;
  logic              wb_en_s;
  logic [31:0]       wb_data_s;
  logic [ADDR_WIDTH-1:0] aligned_addr_s;

  // Decode the current request and the write-back selection.
  always_comb begin
    access_s       = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
    ack_s          = (state_r == ACCESS) & dmem_ack;
    wb_sel_s       = (state_r == ACCESS) & ex_mem_mem_to_reg;
    wb_en_s        = wb_enable(ex_mem_valid, ex_mem_reg_write, ex_mem_mem_write, ex_mem_dest_reg);
    wb_load_s      = ((state_r == IDLE) & ~access_s) | ack_s;
    aligned_addr_s = {ex_mem_alu_result[ADDR_WIDTH-1:2], 2'b00};
  end

  // Stall is released on ack or on the final timeout cycle so the instruction retires.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = access_s;
      ACCESS:  stall_s = ~(dmem_ack | (cnt_r == CNT_LAST));
      default: stall_s = 1'b0;
    endcase
    if (reset) begin
      mem_stall = 1'b0;
    end else begin
      mem_stall = stall_s;
    end
  end

  mux2 #(
    .mux_width(32)
  ) u_wb_mux (
    .a  (ex_mem_alu_result),
    .b  (dmem_rdata),
    .sel(wb_sel_s),
    .y  (wb_data_s)
  );

  // Access FSM, timeout counter and registered memory interface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 32'd0;
      mem_error  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (access_s) begin
            state_r    <= ACCESS;
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_mem_write;
            dmem_addr  <= aligned_addr_s;
            dmem_wdata <= ex_mem_store_data;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state_r  <= IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            cnt_r    <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r   <= IDLE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            cnt_r     <= '0;
            mem_error <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r  <= IDLE;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          cnt_r    <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: loads on a completed instruction, otherwise carries a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wb_reg_write       <= 1'b0;
      mem_wb_write_reg_addr  <= 5'd0;
      mem_wb_write_back_data <= 32'd0;
    end else if (wb_load_s) begin
      mem_wb_reg_write       <= wb_en_s;
      mem_wb_write_reg_addr  <= ex_mem_dest_reg;
      mem_wb_write_back_data <= wb_data_s;
    end else begin
      mem_wb_reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Scoreboard bench for mem_wb_pipe_stage: expected write-backs are queued when
// stimulus is driven and compared whenever the DUT performs a register write.
module tb_mem_wb_pipe_stage;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_store_data;
  logic [4:0]  ex_mem_dest_reg;
  logic        ex_mem_mem_to_reg;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_write;
  logic        ex_mem_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall;
  logic        mem_error;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_write_reg_addr;
  logic [31:0] mem_wb_write_back_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [36:0] sb_q[$];

  mem_wb_pipe_stage #(
    .ADDR_WIDTH(10),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .ex_mem_valid          (ex_mem_valid),
    .ex_mem_alu_result     (ex_mem_alu_result),
    .ex_mem_store_data     (ex_mem_store_data),
    .ex_mem_dest_reg       (ex_mem_dest_reg),
    .ex_mem_mem_to_reg     (ex_mem_mem_to_reg),
    .ex_mem_mem_read       (ex_mem_mem_read),
    .ex_mem_mem_write      (ex_mem_mem_write),
    .ex_mem_reg_write      (ex_mem_reg_write),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_rdata            (dmem_rdata),
    .dmem_ack              (dmem_ack),
    .mem_stall             (mem_stall),
    .mem_error             (mem_error),
    .mem_wb_reg_write      (mem_wb_reg_write),
    .mem_wb_write_reg_addr (mem_wb_write_reg_addr),
    .mem_wb_write_back_data(mem_wb_write_back_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every observed register write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && mem_wb_reg_write === 1'b1) begin
      check_val("wb_expected", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() > 0) begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check_val("wb_addr", {27'd0, mem_wb_write_reg_addr}, {27'd0, e[36:32]});
        check_val("wb_data", mem_wb_write_back_data, e[31:0]);
      end
    end
  end

  task automatic idle_inputs();
    ex_mem_valid      = 1'b0;
    ex_mem_alu_result = 32'd0;
    ex_mem_store_data = 32'd0;
    ex_mem_dest_reg   = 5'd0;
    ex_mem_mem_to_reg = 1'b0;
    ex_mem_mem_read   = 1'b0;
    ex_mem_mem_write  = 1'b0;
    ex_mem_reg_write  = 1'b0;
  endtask

  task automatic drive_rtype(input logic [4:0] dest, input logic [31:0] val,
                             input logic reg_write, input logic push);
    ex_mem_valid      = 1'b1;
    ex_mem_alu_result = val;
    ex_mem_store_data = 32'd0;
    ex_mem_dest_reg   = dest;
    ex_mem_mem_to_reg = 1'b0;
    ex_mem_mem_read   = 1'b0;
    ex_mem_mem_write  = 1'b0;
    ex_mem_reg_write  = reg_write;
    if (push && reg_write && dest != 5'd0) sb_q.push_back({dest, val});
  endtask

  // Issue one load/store from IDLE; ack after `wait_cyc` unacked ACCESS cycles, or never.
  task automatic mem_access(input string tag, input logic is_write, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic [4:0] dest, input logic reg_write,
                            input int wait_cyc, input logic never_ack);
    int  stall_n;
    int  req_n;
    int  exp_n;
    logic done;
    logic [31:0] exp_addr;
    ex_mem_valid      = 1'b1;
    ex_mem_alu_result = addr;
    ex_mem_store_data = wdata;
    ex_mem_dest_reg   = dest;
    ex_mem_mem_to_reg = ~is_write;
    ex_mem_mem_read   = ~is_write;
    ex_mem_mem_write  = is_write;
    ex_mem_reg_write  = reg_write;
    if (!is_write && !never_ack && reg_write && dest != 5'd0) sb_q.push_back({dest, rdata});
    exp_addr = addr & 32'h0000_03FC;
    stall_n = 0;
    req_n   = 0;
    done    = 1'b0;
    #1;
    if (mem_stall) stall_n++;
    @(posedge clk); #1;
    check_val({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
    check_val({tag, "_we"}, {31'd0, dmem_we}, {31'd0, is_write});
    check_val({tag, "_addr"}, {22'd0, dmem_addr}, exp_addr);
    if (is_write) check_val({tag, "_wdata"}, dmem_wdata, wdata);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (!never_ack && cyc == wait_cyc) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      #1;
      if (dmem_req) req_n++;
      if (mem_stall) stall_n++;
      else done = 1'b1;
      @(posedge clk); #1;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'hBAD0_BAD0;
    end
    idle_inputs();
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
    exp_n = never_ack ? TB_TIMEOUT : wait_cyc + 1;
    check_val({tag, "_stall_cycles"}, stall_n, exp_n);
    check_val({tag, "_req_cycles"}, req_n, exp_n);
    check_val({tag, "_req_after"}, {31'd0, dmem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", {31'd0, dmem_req}, 32'd0);
    check_val("rst_addr", {22'd0, dmem_addr}, 32'd0);
    check_val("rst_wdata", dmem_wdata, 32'd0);
    check_val("rst_stall", {31'd0, mem_stall}, 32'd0);
    check_val("rst_wb", {26'd0, mem_wb_reg_write, mem_wb_write_reg_addr}, 32'd0);
    check_val("rst_wb_data", mem_wb_write_back_data, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // R-type pass-through and register-0 handling
    drive_rtype(5'd5, 32'h0000_00AA, 1'b1, 1'b1);
    #1;
    check_val("rt_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    check_val("rt_we", {31'd0, mem_wb_reg_write}, 32'd1);
    drive_rtype(5'd3, 32'h1234_5678, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive_rtype(5'd0, 32'h0000_0055, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_val("r0_we", {31'd0, mem_wb_reg_write}, 32'd0);
    check_val("r0_data", mem_wb_write_back_data, 32'h0000_0055);
    drive_rtype(5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive_rtype(5'd7, 32'h0000_0099, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_val("norw_we", {31'd0, mem_wb_reg_write}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;

    mem_access("load", 1'b0, 32'h0000_01F6, 32'd0, 32'hDEAD_BEEF, 5'd8, 1'b1, 2, 1'b0);
    @(posedge clk); #1;
    mem_access("store", 1'b1, 32'h0000_0010, 32'h0000_1234, 32'h0, 5'd9, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    mem_access("load_fast", 1'b0, 32'h0000_0104, 32'd0, 32'hCAFE_F00D, 5'd12, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    check_val("err_before", {31'd0, mem_error}, 32'd0);
    mem_access("timeout", 1'b0, 32'h0000_0200, 32'd0, 32'h0, 5'd10, 1'b1, 0, 1'b1);
    check_val("err_set", {31'd0, mem_error}, 32'd1);

    // Stray ack in IDLE together with an R-type: write-back must carry the ALU value
    drive_rtype(5'd11, 32'h0000_0BCD, 1'b1, 1'b1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    #1;
    check_val("stray_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    idle_inputs();
    check_val("stray_req", {31'd0, dmem_req}, 32'd0);
    check_val("err_sticky", {31'd0, mem_error}, 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset with a valid write-back pending in MEM/WB
    drive_rtype(5'd9, 32'h0000_0077, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_val("pre_rst_we", {31'd0, mem_wb_reg_write}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("arst_we", {31'd0, mem_wb_reg_write}, 32'd0);
    check_val("arst_stall", {31'd0, mem_stall}, 32'd0);
    check_val("arst_err", {31'd0, mem_error}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    @(posedge clk); #1;

    // Asynchronous reset while an access is outstanding
    ex_mem_valid      = 1'b1;
    ex_mem_mem_read   = 1'b1;
    ex_mem_mem_to_reg = 1'b1;
    ex_mem_reg_write  = 1'b1;
    ex_mem_dest_reg   = 5'd4;
    ex_mem_alu_result = 32'h0000_0040;
    @(posedge clk); #1;
    check_val("acc_req", {31'd0, dmem_req}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("acc_rst_req", {31'd0, dmem_req}, 32'd0);
    check_val("acc_rst_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe_stage.md
Name: mem_wb_pipe_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS core.
- Takes EX/MEM results and issues loads/stores to a variable-latency data memory over a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Produces the write-back triple (mem_wb_reg_write, mem_wb_write_reg_addr, mem_wb_write_back_data) consumed by ID_pipe_stage's register-file write port.

Parameters:
ADDR_WIDTH, 10, byte-address width of data memory (matches 10-bit PC space)
TIMEOUT, 16, max cycles in ACCESS waiting for dmem_ack before abort (>=2)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
ex_mem_valid  in  1  EX/MEM holds a real instruction (0 = bubble)
ex_mem_alu_result  in  32  ALU result / effective address
ex_mem_store_data  in  32  rt value for sw
ex_mem_dest_reg  in  5  destination register
ex_mem_mem_to_reg  in  1  write-back selects load data
ex_mem_mem_read  in  1  lw
ex_mem_mem_write  in  1  sw
ex_mem_reg_write  in  1  instruction writes a register
dmem_req  out  1  access request, registered
dmem_we  out  1  1 = store, valid with dmem_req
dmem_addr  out  ADDR_WIDTH  word-aligned byte address (alu_result[ADDR_WIDTH-1:2], 2'b00)
dmem_wdata  out  32  store data
dmem_rdata  in  32  load data, valid with dmem_ack
dmem_ack  in  1  single-cycle completion pulse
mem_stall  out  1  freeze IF/ID/EX and EX/MEM registers
mem_error  out  1  sticky: access timed out
mem_wb_reg_write  out  1  register-file write enable
mem_wb_write_reg_addr  out  5  register-file write address
mem_wb_write_back_data  out  32  register-file write data

Behaviour:
- Reset (async, immediate): state=IDLE; timeout counter=0; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_wdata=0; mem_error=0; all mem_wb_* =0. mem_stall=0 while reset is high.
- `access` = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write). If both read and write are set, treat as a write.
- IDLE, access=0:
  - mem_stall=0.
  - Next edge: mem_wb_reg_write <= ex_mem_valid & ex_mem_reg_write & (ex_mem_dest_reg!=0).
  - Next edge: addr <= ex_mem_dest_reg; data <= ex_mem_alu_result.
  - Latency 1 cycle.
- IDLE, access=1:
  - mem_stall=1, combinational.
  - Next edge: state->ACCESS; dmem_req<=1; dmem_we<=mem_write; dmem_addr/dmem_wdata latched.
  - Next edge: mem_wb_reg_write<=0 (bubble).
- ACCESS: dmem_req, dmem_we, dmem_addr and dmem_wdata are held constant. Counter increments each cycle.
  - dmem_ack=1:
    - mem_stall=0, combinational.
    - Next edge: dmem_req<=0; state->IDLE; counter<=0.
    - Next edge: MEM/WB loads as in IDLE, with data = mem_to_reg ? dmem_rdata : alu_result. Upstream advances on the same edge.
    - Minimum load latency: 2 cycles (ack in first ACCESS cycle).
  - dmem_ack=0 and counter==TIMEOUT-1:
    - Next edge: dmem_req<=0; state->IDLE; mem_error<=1 (sticky until reset); MEM/WB bubble.
    - mem_stall=0 in that cycle, so the instruction retires with no register write.
  - Otherwise: mem_stall=1; MEM/WB loads bubble (mem_wb_reg_write<=0) each cycle. No duplicate write-back while stalled.
- dmem_ack while IDLE is ignored.
- A new access is never issued in the same cycle as ack. At least one IDLE cycle separates consecutive requests (dmem_req deasserts for ≥1 cycle).
- Register 0: mem_wb_reg_write is never 1 with addr 0; the addr/data fields still load.
- Reset mid-ACCESS: dmem_req drops immediately and the access is abandoned. The memory must tolerate a withdrawn request.
- Stores never assert mem_wb_reg_write, even if ex_mem_reg_write=1.

Decomposition:
- Shared package (mips_pkg):
  - state encoding localparams: IDLE=1'b0, ACCESS=1'b1
  - register-0 constant
  - opcode constants reused by control
- One natural sub-module: reuse existing mux2 (mux_width=32) for the write-back data select.
- FSM, timeout counter and pipeline register stay in this module.

Test Plan:
- Reset: hold reset mid-cycle (async) with ex_mem_valid=1 -> all outputs 0 immediately, mem_stall=0.
- R-type pass-through: valid, reg_write=1, dest=5, alu_result=0x0000_00AA -> next edge mem_wb_reg_write=1, addr=5, data=0xAA; mem_stall never asserted.
- Load, ack after 3 cycles: mem_read, alu_result=0x1F6, dmem_rdata=0xDEAD_BEEF, dest=8 ->
  - dmem_addr=0x1F4, dmem_we=0.
  - mem_stall=1 for 3 cycles, mem_wb_reg_write=0 throughout.
  - On the ack edge: write of 0xDEADBEEF to r8.
  - dmem_req low the following cycle.
- Store: mem_write, alu_result=0x010, store_data=0x1234 -> dmem_we=1, addr=0x010, wdata=0x1234; ack next cycle -> no register write; stall lasts 1 cycle.
- Timeout, TIMEOUT=4, load never acked -> dmem_req high exactly 4 cycles, then mem_error=1 stays set, no write-back, stall released; subsequent R-type still writes back normally.
- Edge cases:
  - dest=0 with reg_write=1 -> mem_wb_reg_write=0.
  - Stray dmem_ack in IDLE -> no state change.
  - Reset asserted during ACCESS -> dmem_req=0 immediately.
